// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
// Shared constants and types for the store buffer and its forwarding matcher.
//   SB_XLEN   : address/data width
//   SB_IDX_HI : upper bit of the word-index field used for address match
//   SB_IDX_LO : lower bit of the word-index field (byte offset is ignored)
//   st_entry_t: one buffered store {addr, data}
package store_buffer_pkg;

  localparam int SB_XLEN   = 32;
  localparam int SB_IDX_HI = 5;
  localparam int SB_IDX_LO = 2;

  typedef struct packed {
    logic [SB_XLEN-1:0] addr;
    logic [SB_XLEN-1:0] data;
  } st_entry_t;

endpackage

// File: rtl/store_fwd_match.sv
// store_fwd_match
// DEPTH-way word-index comparator with youngest-first priority select.
// Ports:
//   i_idx      : word index of every storage slot
//   i_data     : data of every storage slot
//   i_wr_ptr   : next write slot; the youngest valid entry sits at i_wr_ptr-1
//   i_count    : number of valid entries (valid ones are i_wr_ptr-1 .. i_wr_ptr-count)
//   i_ld_valid : a load lookup is being presented
//   i_ld_idx   : word index of the load
//   o_hit      : some valid entry matches the load
//   o_data     : data of the youngest matching entry, 0 when no hit
module store_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_HI = SB_IDX_HI,
  parameter int IDX_LO = SB_IDX_LO
) (
  input  logic [DEPTH-1:0][IDX_HI-IDX_LO:0] i_idx,
  input  logic [DEPTH-1:0][SB_XLEN-1:0]     i_data,
  input  logic [$clog2(DEPTH)-1:0]          i_wr_ptr,
  input  logic [$clog2(DEPTH):0]            i_count,
  input  logic                              i_ld_valid,
  input  logic [IDX_HI-IDX_LO:0]            i_ld_idx,
  output logic                              o_hit,
  output logic [SB_XLEN-1:0]                o_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] w_slot;

  // Walk from oldest (k=DEPTH) to youngest (k=1); the last match assigned
  // is therefore the youngest one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_slot = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_slot = i_wr_ptr - PW'(k);
      if ((CW'(k) <= i_count) && (i_idx[w_slot] == i_ld_idx)) begin
        o_hit  = 1'b1;
        o_data = i_data[w_slot];
      end
    end
    if (!i_ld_valid) begin
      o_hit  = 1'b0;
      o_data = '0;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// In-order FIFO of pending stores between the MEM stage and data memory.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   st_valid/addr/data : store from the pipeline; st_ready = buffer not full
//   ld_valid/ld_addr   : load lookup; fwd_hit/fwd_data give youngest match
//   dm_grant           : data-memory write port free this cycle
//   dm_MemWr/addr/in   : head entry drained into data memory
//   empty/full/count   : occupancy
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_HI = SB_IDX_HI,
  parameter int IDX_LO = SB_IDX_LO
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [SB_XLEN-1:0]       st_addr,
  input  logic [SB_XLEN-1:0]       st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [SB_XLEN-1:0]       ld_addr,
  output logic                     fwd_hit,
  output logic [SB_XLEN-1:0]       fwd_data,
  input  logic                     dm_grant,
  output logic                     dm_MemWr,
  output logic [SB_XLEN-1:0]       dm_addr,
  output logic [SB_XLEN-1:0]       dm_in,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = IDX_HI - IDX_LO + 1;

  st_entry_t               r_mem [DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic                         w_push;
  logic                         w_pop;
  logic [DEPTH-1:0][IW-1:0]     w_idx;
  logic [DEPTH-1:0][SB_XLEN-1:0] w_data;
  logic                         w_unused_ld;

  assign count    = r_count;
  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  // No ready bypass: a pop in a full cycle frees the slot only next cycle.
  assign st_ready = !full;
  assign w_push   = st_valid & st_ready;
  // Drain only from stored entries, so a push into an empty buffer is not
  // written through in the same cycle.
  assign dm_MemWr = !empty & dm_grant;
  assign w_pop    = dm_MemWr;
  assign dm_addr  = empty ? '0 : r_mem[r_rd_ptr].addr;
  assign dm_in    = empty ? '0 : r_mem[r_rd_ptr].data;

  // Only the word-index bits of the load address take part in matching.
  assign w_unused_ld = ^{ld_addr[SB_XLEN-1:IDX_HI+1], ld_addr[IDX_LO-1:0]};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_idx[i]  = r_mem[i].addr[IDX_HI:IDX_LO];
      w_data[i] = r_mem[i].data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents need no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: st_addr, data: st_data};
  end

  store_fwd_match #(
    .DEPTH  (DEPTH),
    .IDX_HI (IDX_HI),
    .IDX_LO (IDX_LO)
  ) u_fwd (
    .i_idx      (w_idx),
    .i_data     (w_data),
    .i_wr_ptr   (r_wr_ptr),
    .i_count    (r_count),
    .i_ld_valid (ld_valid),
    .i_ld_idx   (ld_addr[IDX_HI:IDX_LO]),
    .o_hit      (fwd_hit),
    .o_data     (fwd_data)
  );

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO of pending stores between the MEM stage and the 16-word data memory.
- Accepts one store per cycle from the pipeline and drains one store per cycle into the data memory's primary write port (MemWr/addr/in) when that port is granted.
- Forwards the youngest buffered data to loads whose word index matches a pending entry, so loads never read stale memory.

Parameters:
- DEPTH, 4, number of store entries (power of 2, ≥2)
- IDX_HI, 5, upper bit of word-index field compared for address match
- IDX_LO, 2, lower bit of word-index field (byte offset ignored)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; asserting (0) clears the buffer immediately
- st_valid  in  1  MEM stage presents a store
- st_addr  in  32  store byte address
- st_data  in  32  store data
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  MEM stage presents a load lookup
- ld_addr  in  32  load byte address
- fwd_hit  out  1  a buffered entry matches ld_addr
- fwd_data  out  32  data of the youngest matching entry
- dm_grant  in  1  data-memory primary write port is free this cycle
- dm_MemWr  out  1  write strobe to data memory
- dm_addr  out  32  write address to data memory
- dm_in  out  32  write data to data memory
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: circular array of {addr, data}; wr_ptr, rd_ptr, count registers.
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Entry contents are don't-care. Outputs settle to st_ready=1, empty=1, full=0, dm_MemWr=0, fwd_hit=0, fwd_data=0.
- Reset mid-operation: all pending stores are discarded and none are written.
- Push: push = st_valid & st_ready; st_ready = !full. On posedge, the entry is written at wr_ptr and wr_ptr is incremented modulo DEPTH.
- Drain (combinational from head): dm_MemWr = !empty & dm_grant; dm_addr and dm_data carry the head entry (zero when empty).
  - pop = dm_MemWr. On posedge, rd_ptr is incremented modulo DEPTH.
  - The data memory captures the write on the following negedge of the same cycle.
- Latency: a store pushed in cycle N is first drainable in cycle N+1. It is forwardable from cycle N+1 until the cycle after it pops.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Full boundary: with count=DEPTH, st_ready=0. A simultaneous pop does not free a slot in the same cycle (no ready bypass); st_ready rises the next cycle.
- Empty boundary: a push into an empty buffer is not drained in the same cycle (no write-through).
- Pointer wrap-around is modulo DEPTH. Full/empty are derived only from count.
- Forwarding (combinational):
  - Compare ld_addr[IDX_HI:IDX_LO] against every valid entry's addr[IDX_HI:IDX_LO].
  - fwd_hit = ld_valid & any match.
  - fwd_data = data of the match nearest wr_ptr (youngest); 0 when no hit.
  - The head entry being popped this cycle still forwards, because the memory is not yet written.
  - A store pushed in the same cycle as a load to the same address is not forwarded. Hazard logic upstream stalls that case.
- Ordering: strictly FIFO; multiple stores to one index all drain in order.

Decomposition:
- Shared package contents:
  - word-index field bounds (IDX_HI=5, IDX_LO=2)
  - data/address width constant (32)
  - packed store-entry struct {addr, data}
- One natural sub-module: store_fwd_match, the DEPTH-way index comparator plus youngest-first priority select.

Test Plan:
- Reset with 3 entries pending, reset=0 mid-cycle -> count=0, dm_MemWr=0 immediately; no DM writes after release.
- Push (0x08,0xAA),(0x0C,0xBB) with dm_grant=0, then dm_grant=1 -> dm_MemWr pulses two cycles, dm_addr 0x08 then 0x0C, dm_in 0xAA then 0xBB.
- Fill 4 entries with dm_grant=0 -> full=1, st_ready=0; fifth st_valid ignored. Grant one cycle -> st_ready=1 the next cycle, count=3.
- Push (0x10,0x11) then (0x10,0x22), load ld_addr=0x13 -> fwd_hit=1, fwd_data=0x22. Load 0x14 -> fwd_hit=0.
- Push and pop in the same cycle at count=2 -> count stays 2. Wrap 9 stores through DEPTH=4 -> drain order matches push order.
- Store to 0x04 pushed the same cycle as ld_addr=0x04 on an empty buffer -> fwd_hit=0 that cycle; fwd_hit=1, fwd_data correct next cycle.
